// File: rtl/ps2_rx_interface.sv
// Receive-only PS/2 port: synchronizes and filters the lines, then deframes
// 11-bit device-to-host frames into bytes with a one-cycle strobe.
module ps2_rx_interface #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        ps2_clk,
  inout  wire        ps2_data,
  output logic [7:0] rx_data,
  output logic       read_data,
  output logic       busy,
  output logic       err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } state_t;

  state_t          state, state_n;
  logic            clk_s1, clk_s2;
  logic            dat_s1, dat_s2;
  logic            clk_f, clk_f_d;
  logic [FW-1:0]   fcnt;
  logic [TW-1:0]   tocnt;
  logic [3:0]      bcnt;
  logic [9:0]      sh;
  logic [9:0]      frame;
  logic            fall;
  logic            start;
  logic            fr_done;
  logic            to_hit;
  logic            good;
  logic            tmo;

  assign ps2_clk  = 1'bz;
  assign ps2_data = 1'bz;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      dat_s1  <= 1'b1;
      dat_s2  <= 1'b1;
      clk_f   <= 1'b1;
      clk_f_d <= 1'b1;
      fcnt    <= '0;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      dat_s1  <= ps2_data;
      dat_s2  <= dat_s1;
      clk_f_d <= clk_f;
      if (clk_s2 == clk_f) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILTER_LEN - 1)) begin
        clk_f <= clk_s2;
        fcnt  <= '0;
      end else begin
        fcnt <= fcnt + FW'(1);
      end
    end
  end

  assign fall  = clk_f_d & ~clk_f;
  // New bit enters at the top; the stop bit lands in frame[9].
  assign frame = {dat_s2, sh[9:1]};
  assign good  = frame[9] & (^frame[8:0]);
  assign tmo   = (tocnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    start     = 1'b0;
    fr_done   = 1'b0;
    to_hit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall && !dat_s2) begin
          state_n = RECV;
          start   = 1'b1;
        end
      end
      RECV: begin
        if (fall && bcnt == 4'd9) begin
          state_n = DONE;
          fr_done = 1'b1;
        end else if (!fall && tmo) begin
          state_n = IDLE;
          to_hit  = 1'b1;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy      = start || (state != IDLE);
    read_data = (state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcnt    <= '0;
      tocnt   <= '0;
      sh      <= '0;
      rx_data <= 8'h00;
      err     <= 1'b0;
    end else begin
      if (state == RECV) begin
        if (fall) begin
          sh    <= frame;
          bcnt  <= bcnt + 4'd1;
          tocnt <= '0;
        end else begin
          tocnt <= tocnt + TW'(1);
        end
      end else begin
        bcnt  <= '0;
        tocnt <= '0;
      end
      if (fr_done) begin
        if (good) rx_data <= frame[7:0];
        err <= ~good;
      end
      if (to_hit) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_rx_interface.sv
// Bench for ps2_rx_interface: directed frames, expected bytes queued by
// the stimulus and checked by a strobe monitor.
module tb_ps2_rx_interface;

  localparam int FL  = 8;
  localparam int TO  = 3000;
  localparam int HB  = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       drv_c = 1'b1;
  logic       drv_d = 1'b1;
  wire        ps2_clk;
  wire        ps2_data;
  logic [7:0] rx_data;
  logic       read_data;
  logic       busy;
  logic       err;

  int n_vec = 0;
  int n_bad = 0;
  logic [8:0] q[$];

  assign ps2_clk  = drv_c;
  assign ps2_data = drv_d;

  ps2_rx_interface #(
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_data  (rx_data),
    .read_data(read_data),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic par,
                      input logic stp, input int nb);
    logic [10:0] f;
    f = {stp, par, b, 1'b0};
    for (int i = 0; i < nb; i++) begin
      drv_d = f[i];
      cyc(HB / 2);
      drv_c = 1'b0;
      cyc(HB);
      if (i == 1) chk("busy_in_frame", busy, 1);
      drv_c = 1'b1;
      cyc(HB / 2);
    end
    drv_d = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!reset && read_data) begin
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_strobe: got rx_data %0h err %0b expected none",
                 rx_data, err);
      end else begin
        logic [8:0] e;
        e = q.pop_front();
        chk("strobe_rx_data", rx_data, e[7:0]);
        chk("strobe_err", err, e[8]);
      end
    end
  end

  initial begin
    cyc(2);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_read_data", read_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    cyc(20);
    chk("idle_busy", busy, 0);

    q.push_back({1'b0, 8'h1C});
    send(8'h1C, 1'b0, 1'b1, 11);
    cyc(HB);
    chk("t1_drain", q.size(), 0);
    chk("t1_busy", busy, 0);

    q.push_back({1'b0, 8'hF0});
    q.push_back({1'b0, 8'h1C});
    send(8'hF0, 1'b1, 1'b1, 11);
    send(8'h1C, 1'b0, 1'b1, 11);
    cyc(HB);
    chk("t2_drain", q.size(), 0);

    q.push_back({1'b1, 8'h1C});
    send(8'h1C, 1'b1, 1'b1, 11);
    cyc(HB);
    chk("t3_bad_drain", q.size(), 0);
    chk("t3_err_held", err, 1);
    q.push_back({1'b0, 8'h32});
    send(8'h32, 1'b0, 1'b1, 11);
    cyc(HB);
    chk("t3_good_drain", q.size(), 0);

    q.push_back({1'b1, 8'h32});
    send(8'h1C, 1'b0, 1'b0, 11);
    cyc(HB);
    chk("t4_stop_drain", q.size(), 0);
    drv_c = 1'b0;
    cyc(3);
    drv_c = 1'b1;
    cyc(HB);
    chk("t4_glitch_busy", busy, 0);
    chk("t4_glitch_err", err, 1);
    chk("t4_glitch_rx", rx_data, 8'h32);

    q.push_back({1'b0, 8'h32});
    send(8'h32, 1'b0, 1'b1, 11);
    cyc(HB);
    send(8'h1C, 1'b0, 1'b1, 5);
    cyc(HB);
    chk("t5_busy_open", busy, 1);
    cyc(TO + 50);
    chk("t5_busy", busy, 0);
    chk("t5_err", err, 1);
    chk("t5_rx", rx_data, 8'h32);
    chk("t5_drain", q.size(), 0);
    q.push_back({1'b0, 8'h1C});
    send(8'h1C, 1'b0, 1'b1, 11);
    cyc(HB);
    chk("t5_after_drain", q.size(), 0);

    q.push_back({1'b1, 8'h1C});
    send(8'h1C, 1'b1, 1'b1, 11);
    cyc(HB);
    send(8'h32, 1'b0, 1'b1, 6);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rx", rx_data, 8'h00);
    chk("t6_busy", busy, 0);
    chk("t6_err", err, 0);
    chk("t6_read", read_data, 0);
    cyc(3);
    reset = 1'b0;
    cyc(20);
    q.push_back({1'b0, 8'h1C});
    send(8'h1C, 1'b0, 1'b1, 11);
    cyc(HB);
    chk("t6_drain", q.size(), 0);
    chk("t6_busy_end", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
